// File: rtl/shift_seq_ctrl.sv
// Sequencer for a universal shift register that has no hold mode: the register is
// held by reloading a shadow copy, and each completed command is checked against it.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    output logic             sr_clr,
    output logic             sr_load,
    output logic             sr_sel,
    output logic             sr_sin,
    output logic [WIDTH-1:0] sr_din,
    input  logic [WIDTH-1:0] sr_q,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_CLEAR = 2'b11} op_t;

    state_t             state, state_nxt;
    op_t                op, op_nxt;
    logic [WIDTH-1:0]   data, data_nxt;
    logic               fill, fill_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   shadow, shadow_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic               err_nxt;
    logic               ready_nxt, clr_nxt, load_nxt, sel_nxt, sin_nxt, done_nxt;
    logic [WIDTH-1:0]   din_nxt;

    // State, latched command fields and output registers; reset keeps the register clearing.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            op        <= OP_LOAD;
            data      <= '0;
            fill      <= 1'b0;
            cnt       <= '0;
            shadow    <= '0;
            result    <= '0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            sr_clr    <= 1'b1;
            sr_load   <= 1'b0;
            sr_sel    <= 1'b0;
            sr_sin    <= 1'b0;
            sr_din    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            op        <= op_nxt;
            data      <= data_nxt;
            fill      <= fill_nxt;
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            result    <= result_nxt;
            err       <= err_nxt;
            cmd_ready <= ready_nxt;
            sr_clr    <= clr_nxt;
            sr_load   <= load_nxt;
            sr_sel    <= sel_nxt;
            sr_sin    <= sin_nxt;
            sr_din    <= din_nxt;
            done      <= done_nxt;
        end
    end

    // Next state/fields, then Moore outputs decoded from the next state so they land registered.
    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        data_nxt   = data;
        fill_nxt   = fill;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        result_nxt = result;
        err_nxt    = err;
        ready_nxt  = 1'b0;
        clr_nxt    = 1'b0;
        load_nxt   = 1'b0;
        sel_nxt    = 1'b0;
        sin_nxt    = 1'b0;
        din_nxt    = '0;
        done_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nxt   = op_t'(cmd_op);
                    data_nxt = cmd_data;
                    fill_nxt = cmd_fill;
                    cnt_nxt  = cmd_count;
                    if ((op_t'(cmd_op) == OP_SHL || op_t'(cmd_op) == OP_SHR) && cmd_count == '0)
                        state_nxt = DONE;
                    else
                        state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (op)
                    OP_LOAD: begin
                        shadow_nxt = data;
                        state_nxt  = DONE;
                    end
                    OP_CLEAR: begin
                        shadow_nxt = '0;
                        state_nxt  = DONE;
                    end
                    OP_SHL, OP_SHR: begin
                        if (op == OP_SHL)
                            shadow_nxt = {shadow[WIDTH-2:0], fill};
                        else
                            shadow_nxt = {fill, shadow[WIDTH-1:1]};
                        // Count never reaches zero here: zero-count shifts bypass EXEC.
                        if (cnt == CNT_W'(1))
                            state_nxt = DONE;
                        else
                            cnt_nxt = cnt - CNT_W'(1);
                    end
                endcase
            end
            DONE: begin
                result_nxt = sr_q;
                err_nxt    = err | (sr_q != shadow);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            IDLE: begin
                ready_nxt = 1'b1;
                load_nxt  = 1'b1;
                din_nxt   = shadow_nxt;
            end
            EXEC: begin
                case (op_nxt)
                    OP_LOAD: begin
                        load_nxt = 1'b1;
                        din_nxt  = data_nxt;
                    end
                    OP_CLEAR: clr_nxt = 1'b1;
                    OP_SHL, OP_SHR: begin
                        sel_nxt = (op_nxt == OP_SHL);
                        sin_nxt = fill_nxt;
                    end
                endcase
            end
            DONE: begin
                done_nxt = 1'b1;
                load_nxt = 1'b1;
                din_nxt  = shadow_nxt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural universal shift register
// that can be told to corrupt bit 0 on loads.
module tb_shift_seq_ctrl;

    logic       clk;
    logic       clr_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_count;
    logic       cmd_fill;
    logic       sr_clr, sr_load, sr_sel, sr_sin;
    logic [3:0] sr_din;
    logic [3:0] sr_q;
    logic       done;
    logic [3:0] result;
    logic       err;
    logic       corrupt;
    int         tests;
    int         fails;
    int         acc_cnt;

    shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .cmd_fill  (cmd_fill),
        .sr_clr    (sr_clr),
        .sr_load   (sr_load),
        .sr_sel    (sr_sel),
        .sr_sin    (sr_sin),
        .sr_din    (sr_din),
        .sr_q      (sr_q),
        .done      (done),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register with no hold mode: clear, else load, else shift every edge.
    always @(posedge clk) begin
        if (sr_clr)       sr_q <= 4'b0000;
        else if (sr_load) sr_q <= sr_din ^ {3'b000, corrupt};
        else if (sr_sel)  sr_q <= {sr_q[2:0], sr_sin};
        else              sr_q <= {sr_sin, sr_q[3:1]};
    end

    always @(posedge clk)
        if (clr_n && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command, then count cycles from the accept edge until done is seen.
    task automatic issue(input logic [1:0] op, input logic [3:0] d, input logic [2:0] c,
                         input logic f, output int lat, output int sel_cnt);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin step(); n++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = c; cmd_fill = f;
        step();
        cmd_valid = 1'b0;
        lat = 1;
        sel_cnt = 0;
        while (!done && lat < 20) begin
            sel_cnt += int'(sr_sel);
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, sel_cnt, a0;
        tests = 0; fails = 0; acc_cnt = 0; corrupt = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'b0000; cmd_count = 3'd0; cmd_fill = 1'b0;
        clr_n = 1'b1;
        #2 clr_n = 1'b0;
        #1;
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_sr_clr", 32'(sr_clr), 1);
        check("rst_sr_load", 32'(sr_load), 0);
        step(); step();
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_result", 32'(result), 0);
        check("rst_sr_q", 32'(sr_q), 0);
        clr_n = 1'b1;
        step();
        check("ready_after_rst", 32'(cmd_ready), 1);

        // Idle holding
        for (int i = 0; i < 5; i++) step();
        check("idle_sr_q", 32'(sr_q), 0);
        check("idle_err", 32'(err), 0);
        check("idle_done", 32'(done), 0);
        check("idle_sel_sin", 32'({sr_sel, sr_sin}), 0);

        // LOAD 1011
        issue(2'b00, 4'b1011, 3'd0, 1'b0, lat, sel_cnt);
        check("load_lat", 32'(lat), 2);
        step();
        check("load_result", 32'(result), 32'hB);
        for (int i = 0; i < 10; i++) step();
        check("load_hold", 32'(sr_q), 32'hB);

        // LOAD 1111, SHL 2 fill 0
        issue(2'b00, 4'b1111, 3'd0, 1'b0, lat, sel_cnt);
        step();
        issue(2'b01, 4'b0000, 3'd2, 1'b0, lat, sel_cnt);
        check("shl_lat", 32'(lat), 3);
        check("shl_sel_cycles", 32'(sel_cnt), 2);
        step();
        check("shl_result", 32'(result), 32'hC);

        // LOAD 1000, SHR 6 fill 1, then zero-count shift
        issue(2'b00, 4'b1000, 3'd0, 1'b0, lat, sel_cnt);
        step();
        issue(2'b10, 4'b0000, 3'd6, 1'b1, lat, sel_cnt);
        check("shr_lat", 32'(lat), 7);
        check("shr_sel_cycles", 32'(sel_cnt), 0);
        step();
        check("shr_result", 32'(result), 32'hF);
        issue(2'b01, 4'b0000, 3'd0, 1'b0, lat, sel_cnt);
        check("cnt0_lat", 32'(lat), 1);
        step();
        check("cnt0_result", 32'(result), 32'hF);
        check("cnt0_err", 32'(err), 0);

        // Reset in the middle of SHL 4
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 3'd4; cmd_fill = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("mid_sel", 32'(sr_sel), 1);
        step();
        clr_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(cmd_ready), 0);
        check("mid_rst_ctl", 32'({sr_clr, sr_load, sr_sel, sr_sin}), 32'h8);
        check("mid_rst_result", 32'(result), 0);
        step();
        check("mid_rst_done1", 32'(done), 0);
        step();
        check("mid_rst_done2", 32'(done), 0);
        check("mid_rst_sr_q", 32'(sr_q), 0);
        clr_n = 1'b1;
        step();
        check("mid_ready", 32'(cmd_ready), 1);
        issue(2'b00, 4'b0011, 3'd0, 1'b0, lat, sel_cnt);
        check("post_rst_lat", 32'(lat), 2);
        step();
        check("post_rst_result", 32'(result), 32'h3);
        check("post_rst_err", 32'(err), 0);

        // Corrupting register sets the sticky error
        corrupt = 1'b1;
        issue(2'b00, 4'b0101, 3'd0, 1'b0, lat, sel_cnt);
        check("corr_err_at_done", 32'(err), 0);
        step();
        corrupt = 1'b0;
        check("corr_err", 32'(err), 1);
        check("corr_result", 32'(result), 32'h4);
        issue(2'b11, 4'b0000, 3'd0, 1'b0, lat, sel_cnt);
        check("clear_lat", 32'(lat), 2);
        step();
        check("clear_result", 32'(result), 0);
        check("err_sticky", 32'(err), 1);

        // cmd_valid held through EXEC and DONE gives a single accept
        a0 = acc_cnt;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b0110;
        step(); step(); step();
        cmd_valid = 1'b0;
        check("hold_valid_accepts", 32'(acc_cnt - a0), 1);
        check("hold_valid_ready", 32'(cmd_ready), 1);
        check("hold_valid_sr_q", 32'(sr_q), 32'h6);

        clr_n = 1'b0;
        #1;
        check("err_cleared", 32'(err), 0);
        step();
        clr_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the controlled universal shift register.
REQ-002 The block SHALL have parameter CNT_W, default 3, giving the width of the shift-count field.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the controller accepts a command this cycle.
REQ-007 The block SHALL have port cmd_op, input, 2 bits: 00 LOAD, 01 SHL (shift left), 10 SHR (shift right), 11 CLEAR.
REQ-008 The block SHALL have port cmd_data, input, WIDTH bits: parallel word for LOAD.
REQ-009 The block SHALL have port cmd_count, input, CNT_W bits: number of shift cycles for SHL/SHR.
REQ-010 The block SHALL have port cmd_fill, input, 1 bit: serial-in value used for every shift of the command.
REQ-011 The block SHALL have ports sr_clr, sr_load, sr_sel and sr_sin, outputs, 1 bit each: clear, load, direction (1 = left) and serial-in controls to the shift register.
REQ-012 The block SHALL have port sr_din, output, WIDTH bits: parallel data to the shift register.
REQ-013 The block SHALL have port sr_q, input, WIDTH bits: shift register contents.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port result, output, WIDTH bits: sr_q captured at completion.
REQ-016 The block SHALL have port err, output, 1 bit: sticky flag for a mismatch between sr_q and the shadow copy.

Function
REQ-017 The controlled register SHALL be treated as having no hold mode: it clears on clr, else loads on load, else shifts every cycle; the controller SHALL hold it by reloading it.
REQ-018 The controller SHALL keep a WIDTH-bit shadow register that mirrors the expected register contents after every edge.
REQ-019 The FSM SHALL have states IDLE, EXEC and DONE, with Moore outputs decoded from state and registered fields only.
REQ-020 In IDLE, the controller SHALL drive cmd_ready=1, sr_load=1 and sr_din=shadow, so the register holds.
REQ-021 A command SHALL be accepted on an edge with cmd_valid=1 and cmd_ready=1; op, data, count and fill SHALL be latched at that edge.
REQ-022 cmd_ready SHALL be 0 in EXEC and DONE, and commands offered there SHALL be ignored (not queued).
REQ-023 On acceptance, the next state SHALL be EXEC, except SHL/SHR with count=0, which SHALL go directly to DONE.
REQ-024 LOAD SHALL occupy EXEC for 1 cycle with sr_load=1 and sr_din=latched data; shadow<=data.
REQ-025 CLEAR SHALL occupy EXEC for 1 cycle with sr_clr=1; shadow<=0.
REQ-026 SHL/SHR SHALL occupy EXEC for exactly count cycles with sr_clr=0, sr_load=0, sr_sel=(op==SHL) and sr_sin=fill.
REQ-027 During each SHL/SHR cycle, the shadow SHALL update as {shadow[WIDTH-2:0],fill} for left and {fill,shadow[WIDTH-1:1]} for right.
REQ-028 Counts greater than WIDTH SHALL be legal; the result is an all-fill word.
REQ-029 The internal down-counter SHALL be CNT_W bits and SHALL NOT wrap: EXEC exits when it reaches 1.
REQ-030 In DONE (1 cycle), the controller SHALL drive done=1, sr_load=1 and sr_din=shadow, and SHALL capture result<=sr_q.
REQ-031 In DONE, err SHALL be set if sr_q!=shadow, and err SHALL stay set until reset; DONE SHALL then return to IDLE.
REQ-032 Latency from the accept edge to done high SHALL be 2 cycles for LOAD/CLEAR, count+1 cycles for a shift with count≥1, and 1 cycle for a count=0 shift.
REQ-033 Back-to-back commands SHALL be possible: minimum issue interval is latency+1 cycles (the IDLE cycle).
REQ-034 In all states, sr_clr and sr_load SHALL never both be 1, except during reset.
REQ-035 sr_sel and sr_sin SHALL be 0 in IDLE, DONE and for LOAD/CLEAR.

Reset
REQ-036 clr_n=0 SHALL immediately force state=IDLE, shadow=0, counter=0, result=0, err=0, done=0 and cmd_ready=0.
REQ-037 While clr_n=0, the controller SHALL drive sr_clr=1 and sr_load=0, so the register clears on each clock.
REQ-038 Reset asserted mid-command SHALL abandon the command with no done pulse.
REQ-039 cmd_ready SHALL rise in the first cycle after clr_n deasserts.

Verification
REQ-040 The bench SHALL cover: reset, then 5 idle cycles with sr_q=0000 -> sr_q stays 0000, err=0, done=0.
REQ-041 The bench SHALL cover: LOAD 1011 -> done 2 cycles after accept, result=1011; sr_q still 1011 10 cycles later.
REQ-042 The bench SHALL cover: LOAD 1111, then SHL count=2 fill=0 -> sr_sel=1 for exactly 2 cycles, done at accept+3, result=1100.
REQ-043 The bench SHALL cover: LOAD 1000, then SHR count=6 fill=1 -> result=1111 at accept+7; a count=0 shift -> done at accept+1 with result unchanged.
REQ-044 The bench SHALL cover: clr_n pulsed low during SHL count=4 at cycle 2 -> no done, outputs at reset values, sr_q=0000; the next LOAD works normally.
REQ-045 The bench SHALL cover: a model register that corrupts bit 0 -> err=1 after the next DONE, staying 1 until reset; cmd_valid held high through EXEC -> only 1 accept per IDLE.
